reg_writeback_queue: RTL and testbench

//   Writer side of the CPU register file's write port (write_data/write_address/RegWrite).

---
 rtl/reg_writeback_queue_pkg.sv | 18 +
 rtl/wb_fifo.sv | 76 +++++++
 rtl/reg_writeback_queue.sv | 132 +++++++++++++
 tb/tb_reg_writeback_queue.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_writeback_queue_pkg.sv
// Shared constants and helpers for the register writeback queue.
// Entries are packed as {addr[REG_ADDR_W-1:0], data}.
package reg_writeback_queue_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int WBQ_DEPTH  = 4;

    // r0 is hardwired, so a read of register 0 never conflicts with a pending write.
    function automatic logic addr_hit(
        input logic [REG_ADDR_W-1:0] sel,
        input logic [REG_ADDR_W-1:0] addr,
        input logic                  valid
    );
        return valid & (sel == addr) & (sel != {REG_ADDR_W{1'b0}});
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order writeback FIFO: up to two pushes and one pop per cycle.
// Exposes every entry's address and valid bit for hazard comparison.
module wb_fifo
    import reg_writeback_queue_pkg::*;
#(
    parameter int  DEPTH      = 4,
    parameter int  DATA_WIDTH = 32,
    localparam int ENTRY_W    = REG_ADDR_W + DATA_WIDTH,
    localparam int PTR_W      = $clog2(DEPTH),
    localparam int CNT_W      = PTR_W + 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push_0,
    input  logic [ENTRY_W-1:0]          push_data_0,
    input  logic                        push_1,
    input  logic [ENTRY_W-1:0]          push_data_1,
    input  logic                        pop,
    output logic [CNT_W-1:0]            count,
    output logic [ENTRY_W-1:0]          head_entry,
    output logic [DEPTH-1:0]            entry_valid,
    output logic [DEPTH*REG_ADDR_W-1:0] entry_addrs
);

    logic [ENTRY_W-1:0] mem_r [DEPTH];
    logic [DEPTH-1:0]   valid_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic [PTR_W-1:0]   wr_ptr_1_s;
    logic               pop_s;

    assign wr_ptr_1_s = wr_ptr_r + PTR_W'(1);
    assign pop_s      = pop & (count_r != {CNT_W{1'b0}});

    // Storage, valid bits, pointers and occupancy; push_1 only ever accompanies push_0.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {ENTRY_W{1'b0}};
            end
            valid_r  <= {DEPTH{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (pop_s) begin
                valid_r[rd_ptr_r] <= 1'b0;
            end
            if (push_0) begin
                mem_r[wr_ptr_r]   <= push_data_0;
                valid_r[wr_ptr_r] <= 1'b1;
            end
            if (push_1) begin
                mem_r[wr_ptr_1_s]   <= push_data_1;
                valid_r[wr_ptr_1_s] <= 1'b1;
            end
            rd_ptr_r <= rd_ptr_r + PTR_W'(pop_s);
            wr_ptr_r <= wr_ptr_r + PTR_W'(push_0) + PTR_W'(push_1);
            count_r  <= count_r + CNT_W'(push_0) + CNT_W'(push_1) - CNT_W'(pop_s);
        end
    end

    // Flatten entry addresses for the comparators in the top level.
    always_comb begin
        entry_addrs = {(DEPTH*REG_ADDR_W){1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            entry_addrs[i*REG_ADDR_W +: REG_ADDR_W] = mem_r[i][ENTRY_W-1 -: REG_ADDR_W];
        end
    end

    assign count       = count_r;
    assign head_entry  = mem_r[rd_ptr_r];
    assign entry_valid = valid_r;

endmodule

// File: rtl/reg_writeback_queue.sv
// Writeback queue feeding the register-file write port from ALU and load producers.
// Load has priority; r0 writes are acknowledged but dropped; hazards cover all pending entries.
module reg_writeback_queue
    import reg_writeback_queue_pkg::*;
#(
    parameter int DEPTH      = WBQ_DEPTH,
    parameter int data_width = DATA_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [REG_ADDR_W-1:0]      alu_addr,
    input  logic [data_width-1:0]      alu_data,
    input  logic                       mem_valid,
    output logic                       mem_ready,
    input  logic [REG_ADDR_W-1:0]      mem_addr,
    input  logic [data_width-1:0]      mem_data,
    output logic                       RegWrite,
    output logic [REG_ADDR_W-1:0]      write_address,
    output logic [data_width-1:0]      write_data,
    input  logic [REG_ADDR_W-1:0]      read_sel_1,
    input  logic [REG_ADDR_W-1:0]      read_sel_2,
    output logic                       hazard_1,
    output logic                       hazard_2,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int ENTRY_W = REG_ADDR_W + data_width;

    logic [CNT_W-1:0]            count_s;
    logic [CNT_W-1:0]            free_s;
    logic                        mem_ready_s;
    logic                        alu_ready_s;
    logic                        mem_push_s;
    logic                        alu_push_s;
    logic                        push_0_s;
    logic                        push_1_s;
    logic [ENTRY_W-1:0]          push_data_0_s;
    logic [ENTRY_W-1:0]          push_data_1_s;
    logic                        pop_s;
    logic [ENTRY_W-1:0]          head_entry_s;
    logic [DEPTH-1:0]            entry_valid_s;
    logic [DEPTH*REG_ADDR_W-1:0] entry_addrs_s;
    logic                        hazard_1_s;
    logic                        hazard_2_s;

    assign free_s = CNT_W'(DEPTH) - count_s;

    // Readiness uses only the registered count, so a same-cycle pop never frees space.
    always_comb begin
        mem_ready_s = 1'b0;
        alu_ready_s = 1'b0;
        if (rst) begin
            mem_ready_s = 1'b0;
            alu_ready_s = 1'b0;
        end else begin
            mem_ready_s = (free_s >= CNT_W'(1));
            alu_ready_s = (free_s >= CNT_W'(2)) | ((free_s >= CNT_W'(1)) & ~mem_valid);
        end
    end

    assign mem_push_s = mem_valid & mem_ready_s & (mem_addr != {REG_ADDR_W{1'b0}});
    assign alu_push_s = alu_valid & alu_ready_s & (alu_addr != {REG_ADDR_W{1'b0}});

    // Slot 0 takes the load when present so it lands ahead of the ALU result.
    always_comb begin
        push_0_s      = mem_push_s | alu_push_s;
        push_1_s      = mem_push_s & alu_push_s;
        push_data_1_s = {alu_addr, alu_data};
        if (mem_push_s) begin
            push_data_0_s = {mem_addr, mem_data};
        end else begin
            push_data_0_s = {alu_addr, alu_data};
        end
    end

    assign pop_s = (count_s != {CNT_W{1'b0}});

    wb_fifo #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (data_width)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_0      (push_0_s),
        .push_data_0 (push_data_0_s),
        .push_1      (push_1_s),
        .push_data_1 (push_data_1_s),
        .pop         (pop_s),
        .count       (count_s),
        .head_entry  (head_entry_s),
        .entry_valid (entry_valid_s),
        .entry_addrs (entry_addrs_s)
    );

    // Compare both decode selects against every valid entry, head included.
    always_comb begin
        hazard_1_s = 1'b0;
        hazard_2_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            hazard_1_s = hazard_1_s |
                addr_hit(read_sel_1, entry_addrs_s[i*REG_ADDR_W +: REG_ADDR_W], entry_valid_s[i]);
            hazard_2_s = hazard_2_s |
                addr_hit(read_sel_2, entry_addrs_s[i*REG_ADDR_W +: REG_ADDR_W], entry_valid_s[i]);
        end
    end

    // Write-port outputs come straight from the head register, forced to zero when idle or in reset.
    always_comb begin
        RegWrite      = 1'b0;
        write_address = {REG_ADDR_W{1'b0}};
        write_data    = {data_width{1'b0}};
        if (!rst && pop_s) begin
            RegWrite      = 1'b1;
            write_address = head_entry_s[ENTRY_W-1 -: REG_ADDR_W];
            write_data    = head_entry_s[data_width-1:0];
        end else begin
            RegWrite      = 1'b0;
            write_address = {REG_ADDR_W{1'b0}};
            write_data    = {data_width{1'b0}};
        end
    end

    assign alu_ready = alu_ready_s;
    assign mem_ready = mem_ready_s;
    assign hazard_1  = hazard_1_s & ~rst;
    assign hazard_2  = hazard_2_s & ~rst;
    assign count     = count_s;

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed bench for reg_writeback_queue; expected writes go into a scoreboard
// queue and a negedge monitor matches them against the register-file write port.
module tb_reg_writeback_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, mem_valid;
    logic        alu_ready, mem_ready;
    logic [4:0]  alu_addr, mem_addr;
    logic [31:0] alu_data, mem_data;
    logic        RegWrite;
    logic [4:0]  write_address;
    logic [31:0] write_data;
    logic [4:0]  read_sel_1, read_sel_2;
    logic        hazard_1, hazard_2;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;
    logic        mon_en = 1'b0;
    logic [36:0] exp_q [$];

    always #5 clk = ~clk;

    reg_writeback_queue #(.DEPTH(4), .data_width(32)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
        .RegWrite(RegWrite), .write_address(write_address), .write_data(write_data),
        .read_sel_1(read_sel_1), .read_sel_2(read_sel_2),
        .hazard_1(hazard_1), .hazard_2(hazard_2), .count(count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    // Checks readiness against the hand-derived expectation and records what should be written.
    task automatic handshake(input logic exp_mr, input logic exp_ar);
        check("mem_ready", 64'(mem_ready), 64'(exp_mr));
        check("alu_ready", 64'(alu_ready), 64'(exp_ar));
        if (mem_valid && exp_mr && mem_addr != 5'd0) exp_q.push_back({mem_addr, mem_data});
        if (alu_valid && exp_ar && alu_addr != 5'd0) exp_q.push_back({alu_addr, alu_data});
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; mem_valid = 1'b0;
        alu_addr = 5'd0; mem_addr = 5'd0; alu_data = 32'd0; mem_data = 32'd0;
    endtask

    // Monitor: every write on the port must be the oldest outstanding expectation.
    always @(negedge clk) begin
        if (mon_en && RegWrite === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0d data %0h expected no write at %0t",
                         write_address, write_data, $time);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                check("write_address", 64'(write_address), 64'(e[36:32]));
                check("write_data", 64'(write_data), 64'(e[31:0]));
            end
        end
    end

    int exp_cnt [8] = '{0, 2, 3, 3, 3, 3, 3, 3};

    initial begin
        rst = 1'b1;
        idle_inputs();
        read_sel_1 = 5'd0; read_sel_2 = 5'd0;

        // 1: reset
        to_pos();
        #1;
        check("rst_regwrite", 64'(RegWrite), 64'd0);
        check("rst_mem_ready", 64'(mem_ready), 64'd0);
        check("rst_alu_ready", 64'(alu_ready), 64'd0);
        check("rst_write_address", 64'(write_address), 64'd0);
        to_pos();
        rst = 1'b0;
        mon_en = 1'b1;
        #1;
        check("reset_count", 64'(count), 64'd0);
        check("reset_regwrite", 64'(RegWrite), 64'd0);
        check("reset_hazard_1", 64'(hazard_1), 64'd0);
        check("reset_hazard_2", 64'(hazard_2), 64'd0);
        handshake(1'b1, 1'b1);

        // 2: single ALU request, hazard on the in-flight head
        to_pos();
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF; read_sel_1 = 5'd5;
        #1;
        check("t2_hazard_before_accept", 64'(hazard_1), 64'd0);
        handshake(1'b1, 1'b1);
        to_pos();
        idle_inputs();
        #1;
        check("t2_regwrite", 64'(RegWrite), 64'd1);
        check("t2_write_address", 64'(write_address), 64'd5);
        check("t2_hazard_1", 64'(hazard_1), 64'd1);
        check("t2_count", 64'(count), 64'd1);
        to_pos();
        #1;
        check("t2_count_after", 64'(count), 64'd0);
        check("t2_hazard_after", 64'(hazard_1), 64'd0);
        check("t2_regwrite_after", 64'(RegWrite), 64'd0);

        // 3: simultaneous mem+alu, mem ordered first
        mem_valid = 1'b1; mem_addr = 5'd3; mem_data = 32'h11;
        alu_valid = 1'b1; alu_addr = 5'd4; alu_data = 32'h22;
        read_sel_1 = 5'd3; read_sel_2 = 5'd4;
        #1;
        handshake(1'b1, 1'b1);
        to_pos();
        idle_inputs();
        #1;
        check("t3_count", 64'(count), 64'd2);
        check("t3_first_addr", 64'(write_address), 64'd3);
        check("t3_hazard_1", 64'(hazard_1), 64'd1);
        check("t3_hazard_2", 64'(hazard_2), 64'd1);
        to_pos();
        #1;
        check("t3_second_addr", 64'(write_address), 64'd4);
        check("t3_hazard_1_clear", 64'(hazard_1), 64'd0);
        check("t3_hazard_2_held", 64'(hazard_2), 64'd1);
        to_pos();
        #1;
        check("t3_hazard_2_clear", 64'(hazard_2), 64'd0);
        check("t3_count_empty", 64'(count), 64'd0);
        read_sel_1 = 5'd0; read_sel_2 = 5'd0;

        // 4: both producers streaming; one pop per cycle caps occupancy at 3
        for (int i = 0; i < 8; i++) begin
            if (i != 0) to_pos();
            mem_valid = 1'b1; mem_addr = 5'(6 + i); mem_data = 32'h1000_0000 + 32'(i);
            alu_valid = 1'b1; alu_addr = 5'(16 + i); alu_data = 32'h2000_0000 + 32'(i);
            #1;
            check("t4_count", 64'(count), 64'(exp_cnt[i]));
            handshake((4 - exp_cnt[i]) >= 1, (4 - exp_cnt[i]) >= 2);
        end
        to_pos();
        idle_inputs();
        alu_valid = 1'b1; alu_addr = 5'd24; alu_data = 32'h3000_0000;
        #1;
        check("t4_count_free1", 64'(count), 64'd3);
        handshake(1'b1, 1'b1);
        to_pos();
        idle_inputs();
        repeat (5) to_pos();
        #1;
        check("t4_drained", 64'(count), 64'd0);

        // 5: r0 request is acknowledged but never queued
        alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'hFFFFFFFF; read_sel_1 = 5'd0;
        #1;
        handshake(1'b1, 1'b1);
        check("t5_hazard_1", 64'(hazard_1), 64'd0);
        to_pos();
        idle_inputs();
        #1;
        check("t5_count", 64'(count), 64'd0);
        check("t5_regwrite", 64'(RegWrite), 64'd0);
        check("t5_hazard_1_after", 64'(hazard_1), 64'd0);

        // 6: reset discards pending writes
        mem_valid = 1'b1; mem_addr = 5'd7; mem_data = 32'hA1;
        alu_valid = 1'b1; alu_addr = 5'd8; alu_data = 32'hA2;
        #1;
        handshake(1'b1, 1'b1);
        to_pos();
        mem_valid = 1'b1; mem_addr = 5'd9; mem_data = 32'hB1;
        alu_valid = 1'b1; alu_addr = 5'd10; alu_data = 32'hB2;
        #1;
        handshake(1'b1, 1'b1);
        to_pos();
        idle_inputs();
        rst = 1'b1;
        read_sel_1 = 5'd9;
        #1;
        check("t6_count_before_rst", 64'(count), 64'd3);
        exp_q.delete();
        check("t6_rst_regwrite", 64'(RegWrite), 64'd0);
        check("t6_rst_write_data", 64'(write_data), 64'd0);
        check("t6_rst_hazard_1", 64'(hazard_1), 64'd0);
        check("t6_rst_mem_ready", 64'(mem_ready), 64'd0);
        to_pos();
        rst = 1'b0;
        #1;
        check("t6_count", 64'(count), 64'd0);
        check("t6_regwrite", 64'(RegWrite), 64'd0);
        check("t6_hazard_1", 64'(hazard_1), 64'd0);
        read_sel_1 = 5'd0;
        repeat (4) to_pos();

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
